// File: rtl/xm_mem_arbiter_pkg.sv
// xm_pkg: shared arbiter state type and requester indices
package xm_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_CPU, ARB_DMA} arb_state_t;
  localparam int REQ_CPU = 0;
  localparam int REQ_DMA = 1;
endpackage

// File: rtl/xm_req_latch.sv
// xm_req_latch: captures one requester's pulse, holds its fields until served, returns completion status
module xm_req_latch #(
  parameter int WORD = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            rw,
  input  logic            byte_sel,
  input  logic [WORD-1:0] adr,
  input  logic [WORD-1:0] wdata,
  input  logic            done,
  input  logic            timeout,
  input  logic [WORD-1:0] mem_rdata,
  output logic            pend,
  output logic            rw_q,
  output logic            byte_q,
  output logic [WORD-1:0] adr_q,
  output logic [WORD-1:0] wdata_q,
  output logic [WORD-1:0] rdata,
  output logic            rdy,
  output logic            err
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend <= 1'b0;
      rw_q <= 1'b0;
      byte_q <= 1'b0;
      adr_q <= '0;
      wdata_q <= '0;
      rdata <= '0;
      rdy <= 1'b0;
      err <= 1'b0;
    end else begin
      rdy <= done;
      err <= done && timeout;
      if (done && (timeout || !rw_q)) rdata <= timeout ? '1 : mem_rdata;
      // a new pulse on the completion edge re-arms immediately
      if (en && (!pend || done)) begin
        pend <= 1'b1;
        rw_q <= rw;
        byte_q <= byte_sel;
        adr_q <= adr;
        wdata_q <= wdata;
      end else if (done) pend <= 1'b0;
    end
endmodule

// File: rtl/xm_mem_arbiter.sv
// xm_mem_arbiter: shares one memory port between CPU and DMA with CPU priority and a DMA starvation bound
module xm_mem_arbiter
  import xm_pkg::*;
#(
  parameter int WORD = 16,
  parameter int DMA_MAX_WAIT = 4,
  parameter int TIMEOUT = 64
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic            cpuEn_i,
  input  logic            cpuRW_i,
  input  logic            cpuByte_i,
  input  logic [WORD-1:0] cpuAdr_i,
  input  logic [WORD-1:0] cpuWData_i,
  output logic            cpuBusy_o,
  output logic            cpuRdy_o,
  output logic            cpuErr_o,
  output logic [WORD-1:0] cpuRData_o,
  input  logic            dmaEn_i,
  input  logic            dmaRW_i,
  input  logic            dmaByte_i,
  input  logic [WORD-1:0] dmaAdr_i,
  input  logic [WORD-1:0] dmaWData_i,
  output logic            dmaBusy_o,
  output logic            dmaRdy_o,
  output logic            dmaErr_o,
  output logic [WORD-1:0] dmaRData_o,
  output logic            memEn_o,
  output logic            memRW_o,
  output logic            memByte_o,
  output logic [WORD-1:0] memAdr_o,
  output logic [WORD-1:0] memWData_o,
  input  logic            memAck_i,
  input  logic [WORD-1:0] memRData_i
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int WW = $clog2(DMA_MAX_WAIT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [WW-1:0] W_MAX = WW'(DMA_MAX_WAIT);
  arb_state_t state;
  logic [TW-1:0] tcnt;
  logic [WW-1:0] wait_cnt;
  logic [1:0] en, rw, byt, pend, rw_q, byte_q, done, rdy, err;
  logic [WORD-1:0] adr [2], wdata [2], adr_q [2], wdata_q [2], rdata [2];
  logic expired, grant_cpu, grant_dma, win;
  assign en[REQ_CPU] = cpuEn_i;
  assign en[REQ_DMA] = dmaEn_i;
  assign rw[REQ_CPU] = cpuRW_i;
  assign rw[REQ_DMA] = dmaRW_i;
  assign byt[REQ_CPU] = cpuByte_i;
  assign byt[REQ_DMA] = dmaByte_i;
  assign adr[REQ_CPU] = cpuAdr_i;
  assign adr[REQ_DMA] = dmaAdr_i;
  assign wdata[REQ_CPU] = cpuWData_i;
  assign wdata[REQ_DMA] = dmaWData_i;
  assign expired = tcnt == T_LAST && !memAck_i;
  assign done[REQ_CPU] = state == ARB_CPU && (memAck_i || tcnt == T_LAST);
  assign done[REQ_DMA] = state == ARB_DMA && (memAck_i || tcnt == T_LAST);
  assign grant_dma = state == ARB_IDLE && pend[REQ_DMA] && (!pend[REQ_CPU] || wait_cnt == W_MAX);
  assign grant_cpu = state == ARB_IDLE && pend[REQ_CPU] && !grant_dma;
  assign win = grant_dma;
  for (genvar i = 0; i < 2; i++) begin : g_req
    xm_req_latch #(.WORD(WORD)) u_latch (
      .clk(clk_i), .rst(arst_i), .en(en[i]), .rw(rw[i]), .byte_sel(byt[i]),
      .adr(adr[i]), .wdata(wdata[i]), .done(done[i]), .timeout(expired),
      .mem_rdata(memRData_i), .pend(pend[i]), .rw_q(rw_q[i]), .byte_q(byte_q[i]),
      .adr_q(adr_q[i]), .wdata_q(wdata_q[i]), .rdata(rdata[i]), .rdy(rdy[i]), .err(err[i])
    );
  end
  assign cpuBusy_o = pend[REQ_CPU];
  assign dmaBusy_o = pend[REQ_DMA];
  assign cpuRdy_o = rdy[REQ_CPU];
  assign dmaRdy_o = rdy[REQ_DMA];
  assign cpuErr_o = err[REQ_CPU];
  assign dmaErr_o = err[REQ_DMA];
  assign cpuRData_o = rdata[REQ_CPU];
  assign dmaRData_o = rdata[REQ_DMA];
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) begin
      state <= ARB_IDLE;
      memEn_o <= 1'b0;
      memRW_o <= 1'b0;
      memByte_o <= 1'b0;
      memAdr_o <= '0;
      memWData_o <= '0;
      tcnt <= '0;
      wait_cnt <= '0;
    end else begin
      if (grant_cpu || grant_dma) begin
        state <= grant_dma ? ARB_DMA : ARB_CPU;
        memEn_o <= 1'b1;
        memRW_o <= rw_q[win];
        memByte_o <= byte_q[win];
        memAdr_o <= adr_q[win] & ~WORD'(!byte_q[win]);
        memWData_o <= wdata_q[win];
        tcnt <= '0;
      end else if (|done) begin
        state <= ARB_IDLE;
        memEn_o <= 1'b0;
      end else if (state != ARB_IDLE) tcnt <= tcnt + 1'b1;
      wait_cnt <= (grant_dma || !pend[REQ_DMA]) ? '0 :
                  (grant_cpu && wait_cnt != W_MAX) ? wait_cnt + 1'b1 : wait_cnt;
    end
endmodule

// File: tb/tb_xm_mem_arbiter.sv
// tb_xm_mem_arbiter: directed, table-driven and random checks of xm_mem_arbiter against a cycle-level reference model
module tb_xm_mem_arbiter;
  localparam int MAXW = 4;
  localparam int TMO = 64;
  logic clk = 0, arst_i = 0;
  logic cen = 0, crw = 0, cbyte = 0, den = 0, drw = 0, dbyte = 0, ack = 0;
  logic [15:0] cadr = 0, cwd = 0, dadr = 0, dwd = 0, adata = 0;
  logic cpuBusy_o, cpuRdy_o, cpuErr_o, dmaBusy_o, dmaRdy_o, dmaErr_o, memEn_o, memRW_o, memByte_o;
  logic [15:0] cpuRData_o, dmaRData_o, memAdr_o, memWData_o;
  int total = 0, bad = 0;
  bit hold_c = 0;
  bit m_pend [2];
  logic m_rw [2], m_byte [2];
  logic [15:0] m_adr [2], m_wd [2], m_rd [2];
  int m_owner, m_age, m_ncpu;
  bit e_rdy [2], e_err [2];
  typedef struct {logic rw; logic byt; logic [15:0] adr; logic [15:0] exp_adr;} vec_t;
  vec_t tbl [5];

  xm_mem_arbiter dut (
    .clk_i(clk), .arst_i(arst_i),
    .cpuEn_i(cen), .cpuRW_i(crw), .cpuByte_i(cbyte), .cpuAdr_i(cadr), .cpuWData_i(cwd),
    .cpuBusy_o(cpuBusy_o), .cpuRdy_o(cpuRdy_o), .cpuErr_o(cpuErr_o), .cpuRData_o(cpuRData_o),
    .dmaEn_i(den), .dmaRW_i(drw), .dmaByte_i(dbyte), .dmaAdr_i(dadr), .dmaWData_i(dwd),
    .dmaBusy_o(dmaBusy_o), .dmaRdy_o(dmaRdy_o), .dmaErr_o(dmaErr_o), .dmaRData_o(dmaRData_o),
    .memEn_o(memEn_o), .memRW_o(memRW_o), .memByte_o(memByte_o), .memAdr_o(memAdr_o),
    .memWData_o(memWData_o), .memAck_i(ack), .memRData_i(adata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endtask

  task automatic model_reset;
    for (int x = 0; x < 2; x++) begin
      m_pend[x] = 0; m_rw[x] = 0; m_byte[x] = 0; m_adr[x] = 0; m_wd[x] = 0; m_rd[x] = 0;
      e_rdy[x] = 0; e_err[x] = 0;
    end
    m_owner = 0; m_age = 0; m_ncpu = 0;
  endtask

  // owner: 0 none, 1 CPU, 2 DMA; age: cycles the port has been held
  task automatic model_edge;
    bit dn [2];
    bit dma_turn;
    for (int x = 0; x < 2; x++) begin
      dn[x] = m_owner == x + 1 && (ack || m_age == TMO);
      e_rdy[x] = dn[x];
      e_err[x] = dn[x] && !ack;
      if (e_err[x]) m_rd[x] = 16'hFFFF;
      else if (dn[x] && !m_rw[x]) m_rd[x] = adata;
    end
    if (m_owner != 0) begin
      if (dn[0] || dn[1]) m_owner = 0;
      else m_age++;
    end else if (m_pend[0] || m_pend[1]) begin
      dma_turn = m_pend[1] && (!m_pend[0] || m_ncpu >= MAXW);
      m_owner = dma_turn ? 2 : 1;
      m_age = 1;
      if (dma_turn) m_ncpu = 0;
      else if (m_pend[1] && m_ncpu < MAXW) m_ncpu++;
    end
    if (!m_pend[1]) m_ncpu = 0;
    if (cen && (!m_pend[0] || dn[0])) begin
      m_pend[0] = 1; m_rw[0] = crw; m_byte[0] = cbyte; m_adr[0] = cadr; m_wd[0] = cwd;
    end else if (dn[0]) m_pend[0] = 0;
    if (den && (!m_pend[1] || dn[1])) begin
      m_pend[1] = 1; m_rw[1] = drw; m_byte[1] = dbyte; m_adr[1] = dadr; m_wd[1] = dwd;
    end else if (dn[1]) m_pend[1] = 0;
  endtask

  task automatic check_outs;
    int x;
    chk("cpu_busy", 32'(cpuBusy_o), 32'(m_pend[0]));
    chk("dma_busy", 32'(dmaBusy_o), 32'(m_pend[1]));
    chk("mem_en", 32'(memEn_o), 32'(m_owner != 0));
    chk("cpu_rdy", 32'(cpuRdy_o), 32'(e_rdy[0]));
    chk("dma_rdy", 32'(dmaRdy_o), 32'(e_rdy[1]));
    chk("cpu_err", 32'(cpuErr_o), 32'(e_err[0]));
    chk("dma_err", 32'(dmaErr_o), 32'(e_err[1]));
    chk("cpu_rdata", 32'(cpuRData_o), 32'(m_rd[0]));
    chk("dma_rdata", 32'(dmaRData_o), 32'(m_rd[1]));
    if (m_owner != 0) begin
      x = m_owner - 1;
      chk("mem_adr", 32'(memAdr_o), 32'(m_byte[x] ? m_adr[x] : m_adr[x] & 16'hFFFE));
      chk("mem_rw", 32'(memRW_o), 32'(m_rw[x]));
      chk("mem_byte", 32'(memByte_o), 32'(m_byte[x]));
      chk("mem_wdata", 32'(memWData_o), 32'(m_wd[x]));
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
    model_edge();
    check_outs();
    cen = hold_c;
    den = 0;
    ack = 0;
  endtask

  // acks on the lat-th cycle of memEn_o high (never if lat is huge), returns when a rdy pulse is seen
  task automatic xfer(input int lat, input logic [15:0] d, output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (memEn_o) begin
        n++;
        if (n == lat) begin ack = 1; adata = d; end
      end
      step();
      if (cpuRdy_o || dmaRdy_o) return;
    end
    chk("xfer_budget", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n, got;
    tbl[0] = '{1'b1, 1'b0, 16'h0013, 16'h0012};
    tbl[1] = '{1'b1, 1'b1, 16'h0013, 16'h0013};
    tbl[2] = '{1'b0, 1'b0, 16'h0041, 16'h0040};
    tbl[3] = '{1'b0, 1'b1, 16'h8001, 16'h8001};
    tbl[4] = '{1'b1, 1'b0, 16'hFFFF, 16'hFFFE};
    model_reset();
    #1 arst_i = 1;
    #2;
    chk("rst_mem_en", 32'(memEn_o), 0);
    chk("rst_busy", 32'({cpuBusy_o, dmaBusy_o}), 0);
    chk("rst_rdy", 32'({cpuRdy_o, dmaRdy_o, cpuErr_o, dmaErr_o}), 0);
    chk("rst_mem_adr", 32'(memAdr_o), 0);
    #17 arst_i = 0;
    step();
    // basic CPU read with a 3-cycle memory
    cadr = 16'h0040; crw = 0; cbyte = 0; cen = 1;
    step();
    chk("rd_busy", 32'(cpuBusy_o), 1);
    chk("rd_no_en_yet", 32'(memEn_o), 0);
    xfer(3, 16'hBEEF, n);
    chk("rd_en_cycles", n, 3);
    chk("rd_rdy", 32'(cpuRdy_o), 1);
    chk("rd_data", 32'(cpuRData_o), 16'hBEEF);
    step();
    chk("rd_rdy_pulse", 32'(cpuRdy_o), 0);
    // simultaneous requests: CPU first, one idle cycle, then DMA
    cadr = 16'h0100; crw = 1; cwd = 16'h1234; cen = 1;
    dadr = 16'h0200; drw = 0; dbyte = 0; den = 1;
    step();
    chk("sim_both_busy", 32'({cpuBusy_o, dmaBusy_o}), 2'b11);
    xfer(1, 16'h0, n);
    chk("sim_cpu_first", 32'({cpuRdy_o, dmaRdy_o}), 2'b10);
    chk("sim_dma_wait", 32'(dmaBusy_o), 1);
    chk("sim_idle_gap", 32'(memEn_o), 0);
    step();
    chk("sim_dma_grant", 32'(memEn_o), 1);
    chk("sim_dma_adr", 32'(memAdr_o), 16'h0200);
    xfer(2, 16'hA5A5, n);
    chk("sim_dma_rdy", 32'(dmaRdy_o), 1);
    chk("sim_dma_data", 32'(dmaRData_o), 16'hA5A5);
    chk("sim_cpu_hold", 32'(cpuRData_o), 16'hBEEF);
    // DMA starvation bound with CPU re-requesting every cycle
    cadr = 16'h0300; crw = 0; dadr = 16'h0400; drw = 0; cen = 1; den = 1; hold_c = 1;
    step();
    got = -1;
    for (int g = 0; g < 6; g++) begin
      xfer(1, 16'(g), n);
      if (dmaRdy_o && got < 0) got = g;
    end
    chk("starve_dma_slot", got, 4);
    hold_c = 0; cen = 0;
    xfer(1, 16'h0, n);
    step();
    chk("starve_drained", 32'({cpuBusy_o, dmaBusy_o}), 0);
    // DMA write that never gets acked
    dadr = 16'h0500; drw = 1; dwd = 16'h7777; den = 1;
    step();
    xfer(1000, 16'h0, n);
    chk("to_en_cycles", n, TMO);
    chk("to_rdy_err", 32'({dmaRdy_o, dmaErr_o}), 2'b11);
    chk("to_rdata", 32'(dmaRData_o), 16'hFFFF);
    chk("to_cpu_clean", 32'({cpuRdy_o, cpuErr_o}), 0);
    // address alignment vectors
    foreach (tbl[i]) begin
      crw = tbl[i].rw; cbyte = tbl[i].byt; cadr = tbl[i].adr; cwd = 16'(i); cen = 1;
      step();
      step();
      chk("align_en", 32'(memEn_o), 1);
      chk("align_adr", 32'(memAdr_o), 32'(tbl[i].exp_adr));
      chk("align_byte", 32'(memByte_o), 32'(tbl[i].byt));
      ack = 1; adata = 16'hC000 | 16'(i);
      step();
      chk("align_rdy", 32'(cpuRdy_o), 1);
    end
    // asynchronous reset in the middle of a CPU transfer
    cadr = 16'h0600; crw = 0; cbyte = 0; cen = 1;
    step();
    step();
    chk("arst_pre_en", 32'(memEn_o), 1);
    arst_i = 1;
    #1;
    chk("arst_mem_en", 32'(memEn_o), 0);
    chk("arst_busy", 32'(cpuBusy_o), 0);
    chk("arst_no_rdy", 32'(cpuRdy_o), 0);
    model_reset();
    #4 arst_i = 0;
    cadr = 16'h0700; cen = 1;
    step();
    xfer(2, 16'h1357, n);
    chk("post_rst_en", n, 2);
    chk("post_rst_rdy", 32'(cpuRdy_o), 1);
    chk("post_rst_data", 32'(cpuRData_o), 16'h1357);
    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cen = ($urandom % 4) == 0; crw = 1'($urandom); cbyte = 1'($urandom);
      cadr = 16'($urandom); cwd = 16'($urandom);
      den = ($urandom % 4) == 0; drw = 1'($urandom); dbyte = 1'($urandom);
      dadr = 16'($urandom); dwd = 16'($urandom);
      ack = memEn_o ? ($urandom % 3) == 0 : ($urandom % 8) == 0;
      adata = 16'($urandom);
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
